flash_read_arbiter: RTL

Shares the single byte-wide read port of the QSPI flash reader between two requesters: requester 0 (cartridge/ROM loader) and requester 1 (debug/capture path). Each requester issues burst reads: start address plus length. The arbiter grants bursts round-robin, sequences per-byte reads into the flash reader, and returns data to the owning requester. An optional watchdog aborts bursts when the flash stalls. It sits between the requesters and the flash reader, in the flash clock domain.

---
 rtl/flash_read_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin burst arbiter sharing the byte-wide flash read port between requesters.
// Requester 0 is the ROM loader and requester 1 is the debug capture path.
// Define FLASH_ARB_TIMEOUT_EN to enable the stall watchdog, which aborts a burst after TIMEOUT unanswered cycles.
module flash_read_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic [1:0]        rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              fl_valid,
    output logic [ADDR_W-1:0] fl_addr,
    input  logic              fl_ready,
    input  logic [7:0]        fl_rdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic              pri;
    logic              grant;
    logic              take;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("flash_read_arbiter: TIMEOUT must be at least 1");
    end

    // The pointer side wins a tie; a byte completes only when the flash answers a read that was actually issued
    always_comb begin
        grant = req_valid[pri] ? pri : ~pri;
        take  = (state == RUN) && fl_valid && fl_ready;
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             expire;

    assign expire = (state == RUN) && fl_valid && !fl_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog: counts cycles an issued read has gone unanswered, restarting whenever RUN is re-entered
    always_ff @(posedge clk) begin
        if (!reset_n || state != RUN)
            wait_cnt <= '0;
        else if (fl_valid && !fl_ready)
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Burst sequencer: grant in IDLE, issue one byte read per RUN, insert one idle cycle (GAP) between bytes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            pri       <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            fl_valid  <= 1'b0;
            fl_addr   <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready[grant] <= 1'b1;
                        cur_addr         <= grant ? req_addr1 : req_addr0;
                        remaining        <= grant ? req_len1 : req_len0;
                        owner            <= grant;
                        busy             <= 1'b1;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_data         <= fl_rdata;
                        fl_valid         <= 1'b0;
                        if (remaining == '0) begin
                            rsp_last <= 1'b1;
                            busy     <= 1'b0;
                            pri      <= ~owner;
                            state    <= IDLE;
                        end else begin
                            cur_addr  <= cur_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            state     <= GAP;
                        end
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    else if (expire) begin
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= 1'b1;
                        rsp_last         <= 1'b1;
                        rsp_data         <= '0;
                        fl_valid         <= 1'b0;
                        busy             <= 1'b0;
                        pri              <= ~owner;
                        state            <= IDLE;
                    end
`endif
                    else begin
                        fl_valid <= 1'b1;
                        fl_addr  <= cur_addr;
                    end
                end
                GAP: begin
                    fl_valid <= 1'b1;
                    fl_addr  <= cur_addr;
                    state    <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
